// File: rtl/controle_entrada_rpn.sv
// Input front-end for the 2-level RPN stack/ALU stage.
// Synchronizes and debounces the push-buttons, latches the operand and opcode
// switches, and tracks stack occupancy so that illegal RPN sequences are
// rejected before they reach the stack.
//
// state | meaning
// ------+--------------------------------
// S0    | stack empty
// S1    | one operand on the stack
// S2    | two operands on the stack (full)
module controle_entrada_rpn #(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter int EXEC_HOLDOFF    = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] chaves,
  input  logic [2:0] chaves_op,
  input  logic       btn_numero,
  input  logic       btn_executar,
  input  logic       btn_limpar,
  output logic [7:0] entrada,
  output logic [2:0] operacao,
  output logic       entrada_numero,
  output logic       executar,
  output logic [1:0] nivel,
  output logic       erro_sequencia,
  output logic       ocupado
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] DEB_RELOAD = CW'(DEBOUNCE_CYCLES - 1);
  localparam int HW = (EXEC_HOLDOFF < 1) ? 1 : $clog2(EXEC_HOLDOFF + 1);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(EXEC_HOLDOFF);

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2
  } state_t;

  state_t state, state_next;

  // bit 0: numero, bit 1: executar, bit 2: limpar
  logic [2:0] btn_raw;
  logic [2:0] btn_s1, btn_s2;
  logic [7:0] ch_s1, ch_s2;
  logic [2:0] op_s1, op_s2;
  logic [2:0] level, level_d, ev;
  logic [HW-1:0] hold_cnt;
  logic       busy;
  logic       push_ok, exec_ok, err_next;

  assign btn_raw = {btn_limpar, btn_executar, btn_numero};

  // Two-flop synchronizers for every asynchronous board input.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      btn_s1 <= '0;
      btn_s2 <= '0;
      ch_s1  <= '0;
      ch_s2  <= '0;
      op_s1  <= '0;
      op_s2  <= '0;
    end else begin
      btn_s1 <= btn_raw;
      btn_s2 <= btn_s1;
      ch_s1  <= chaves;
      ch_s2  <= ch_s1;
      op_s1  <= chaves_op;
      op_s2  <= op_s1;
    end
  end

  for (genvar i = 0; i < 3; i++) begin : g_deb
    logic          lvl;
    logic [CW-1:0] cnt;

    // Down-counter restarts on every sample equal to the accepted level;
    // terminal count flips the level after DEBOUNCE_CYCLES differing samples.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        lvl <= 1'b0;
        cnt <= DEB_RELOAD;
      end else if (btn_s2[i] == lvl) begin
        cnt <= DEB_RELOAD;
      end else if (cnt == '0) begin
        lvl <= btn_s2[i];
        cnt <= DEB_RELOAD;
      end else begin
        cnt <= cnt - 1'b1;
      end
    end

    assign level[i] = lvl;
  end

  // Previous debounced level, for rising-edge event detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) level_d <= '0;
    else      level_d <= level;
  end

  assign ev   = level & ~level_d;
  assign busy = executar | (hold_cnt != '0);

  // Occupancy state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S0;
    else      state <= state_next;
  end

  // Next state and command acceptance; limpar beats everything, busy drops
  // numero/executar silently, numero+executar together is one error.
  always_comb begin
    state_next = state;
    push_ok    = 1'b0;
    exec_ok    = 1'b0;
    err_next   = 1'b0;
    if (ev[2]) begin
      state_next = S0;
    end else if (!busy && (ev[0] || ev[1])) begin
      if (ev[0] && ev[1]) begin
        err_next = 1'b1;
      end else if (ev[0]) begin
        if (state == S2) begin
          err_next = 1'b1;
        end else begin
          push_ok    = 1'b1;
          state_next = (state == S0) ? S1 : S2;
        end
      end else begin
        if (state == S2) begin
          exec_ok    = 1'b1;
          state_next = S1;
        end else begin
          err_next = 1'b1;
        end
      end
    end
  end

  // Registered strobes, latched data and post-execute holdoff counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      entrada_numero <= 1'b0;
      executar       <= 1'b0;
      erro_sequencia <= 1'b0;
      entrada        <= '0;
      operacao       <= '0;
      hold_cnt       <= '0;
    end else begin
      entrada_numero <= push_ok;
      executar       <= exec_ok;
      erro_sequencia <= err_next;
      if (push_ok) entrada  <= ch_s2;
      if (exec_ok) operacao <= op_s2;
      if (ev[2])                 hold_cnt <= '0;
      else if (executar)         hold_cnt <= HOLD_LOAD;
      else if (hold_cnt != '0)   hold_cnt <= hold_cnt - 1'b1;
    end
  end

  assign nivel   = state;
  assign ocupado = (hold_cnt != '0);

endmodule

// File: tb/tb_controle_entrada_rpn.sv
// Directed bench for controle_entrada_rpn with DEBOUNCE_CYCLES=4, EXEC_HOLDOFF=2.
module tb_controle_entrada_rpn;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] chaves;
  logic [2:0] chaves_op;
  logic       btn_numero, btn_executar, btn_limpar;
  logic [7:0] entrada;
  logic [2:0] operacao;
  logic       entrada_numero, executar, erro_sequencia, ocupado;
  logic [1:0] nivel;

  controle_entrada_rpn #(.DEBOUNCE_CYCLES(4), .EXEC_HOLDOFF(2)) dut (
    .clk(clk), .rst(rst), .chaves(chaves), .chaves_op(chaves_op),
    .btn_numero(btn_numero), .btn_executar(btn_executar), .btn_limpar(btn_limpar),
    .entrada(entrada), .operacao(operacao), .entrada_numero(entrada_numero),
    .executar(executar), .nivel(nivel), .erro_sequencia(erro_sequencia),
    .ocupado(ocupado)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0] btn;     // {limpar, executar, numero}
    logic [7:0] ch;
    logic [2:0] op;
    int         e_num, e_exe, e_err;
    logic [7:0] e_ent;
    logic [2:0] e_op;
    logic [1:0] e_niv;
    int         e_ocup;
  } vec_t;

  vec_t vecs [14];

  int n_vec = 0, n_fail = 0;
  int cyc, first, n_num, n_exe, n_err, n_ocup, both, wide;
  logic p_num, p_exe, p_err;

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic clear_counts();
    cyc = 0; first = 0; n_num = 0; n_exe = 0; n_err = 0; n_ocup = 0;
  endtask

  task automatic tick();
    @(negedge clk);
    cyc++;
    if (entrada_numero) n_num++;
    if (executar) n_exe++;
    if (erro_sequencia) n_err++;
    if (ocupado) n_ocup++;
    if ((entrada_numero || executar || erro_sequencia) && first == 0) first = cyc;
    if (entrada_numero && executar) both++;
    if ((entrada_numero && p_num) || (executar && p_exe) || (erro_sequencia && p_err)) wide++;
    p_num = entrada_numero; p_exe = executar; p_err = erro_sequencia;
  endtask

  task automatic press(input logic [2:0] b, input logic [7:0] ch, input logic [2:0] op);
    clear_counts();
    chaves = ch; chaves_op = op;
    {btn_limpar, btn_executar, btn_numero} = b;
    repeat (10) tick();
    {btn_limpar, btn_executar, btn_numero} = 3'b000;
    repeat (14) tick();
  endtask

  initial begin
    both = 0; wide = 0; p_num = 0; p_exe = 0; p_err = 0;
    rst = 1'b0; chaves = '0; chaves_op = '0;
    btn_numero = 0; btn_executar = 0; btn_limpar = 0;
    //         btn     ch     op    num exe err  ent    op    niv  ocup
    vecs[0]  = '{3'b001, 8'h05, 3'd0, 1, 0, 0, 8'h05, 3'd0, 2'd1, 0};
    vecs[1]  = '{3'b001, 8'h03, 3'd0, 1, 0, 0, 8'h03, 3'd0, 2'd2, 0};
    vecs[2]  = '{3'b001, 8'h04, 3'd0, 0, 0, 1, 8'h03, 3'd0, 2'd2, 0};
    vecs[3]  = '{3'b010, 8'h00, 3'd1, 0, 1, 0, 8'h03, 3'd1, 2'd1, 2};
    vecs[4]  = '{3'b010, 8'h00, 3'd2, 0, 0, 1, 8'h03, 3'd1, 2'd1, 0};
    vecs[5]  = '{3'b001, 8'h04, 3'd0, 1, 0, 0, 8'h04, 3'd1, 2'd2, 0};
    vecs[6]  = '{3'b100, 8'h00, 3'd0, 0, 0, 0, 8'h04, 3'd1, 2'd0, 0};
    vecs[7]  = '{3'b010, 8'h00, 3'd3, 0, 0, 1, 8'h04, 3'd1, 2'd0, 0};
    vecs[8]  = '{3'b001, 8'hAA, 3'd0, 1, 0, 0, 8'hAA, 3'd1, 2'd1, 0};
    vecs[9]  = '{3'b011, 8'h11, 3'd7, 0, 0, 1, 8'hAA, 3'd1, 2'd1, 0};
    vecs[10] = '{3'b101, 8'h22, 3'd0, 0, 0, 0, 8'hAA, 3'd1, 2'd0, 0};
    vecs[11] = '{3'b001, 8'hFF, 3'd0, 1, 0, 0, 8'hFF, 3'd1, 2'd1, 0};
    vecs[12] = '{3'b001, 8'h12, 3'd0, 1, 0, 0, 8'h12, 3'd1, 2'd2, 0};
    vecs[13] = '{3'b010, 8'h00, 3'd6, 0, 1, 0, 8'h12, 3'd6, 2'd1, 2};

    repeat (3) @(negedge clk);
    chk("reset_entrada", int'(entrada), 0);
    chk("reset_operacao", int'(operacao), 0);
    chk("reset_strobes", int'({entrada_numero, executar, erro_sequencia, ocupado}), 0);
    chk("reset_nivel", int'(nivel), 0);
    rst = 1'b1;
    repeat (2) tick();

    for (int i = 0; i < 14; i++) begin
      press(vecs[i].btn, vecs[i].ch, vecs[i].op);
      chk($sformatf("v%0d_num", i), n_num, vecs[i].e_num);
      chk($sformatf("v%0d_exe", i), n_exe, vecs[i].e_exe);
      chk($sformatf("v%0d_err", i), n_err, vecs[i].e_err);
      chk($sformatf("v%0d_latency", i), first,
          (vecs[i].e_num + vecs[i].e_exe + vecs[i].e_err) > 0 ? 7 : 0);
      chk($sformatf("v%0d_entrada", i), int'(entrada), int'(vecs[i].e_ent));
      chk($sformatf("v%0d_operacao", i), int'(operacao), int'(vecs[i].e_op));
      chk($sformatf("v%0d_nivel", i), int'(nivel), int'(vecs[i].e_niv));
      chk($sformatf("v%0d_ocupado", i), n_ocup, vecs[i].e_ocup);
    end

    // Bouncy numero press: three 2-cycle glitches, then a solid hold.
    clear_counts();
    chaves = 8'h5A;
    for (int k = 0; k < 3; k++) begin
      btn_numero = 1; tick(); tick();
      btn_numero = 0; tick(); tick();
    end
    chk("bounce_glitch_pulses", n_num + n_exe + n_err, 0);
    clear_counts();
    btn_numero = 1;
    repeat (12) tick();
    btn_numero = 0;
    repeat (14) tick();
    chk("bounce_num", n_num, 1);
    chk("bounce_latency", first, 7);
    chk("bounce_entrada", int'(entrada), 8'h5A);
    chk("bounce_nivel", int'(nivel), 2);

    // Numero event lands inside the post-execute holdoff window.
    clear_counts();
    chaves_op = 3'd3; chaves = 8'h99;
    btn_executar = 1; tick(); tick();
    btn_numero = 1;
    repeat (10) tick();
    btn_executar = 0; btn_numero = 0;
    repeat (16) tick();
    chk("hold_exe", n_exe, 1);
    chk("hold_num_dropped", n_num, 0);
    chk("hold_no_err", n_err, 0);
    chk("hold_ocupado", n_ocup, 2);
    chk("hold_operacao", int'(operacao), 3);
    chk("hold_entrada", int'(entrada), 8'h5A);
    chk("hold_nivel", int'(nivel), 1);

    press(3'b001, 8'h33, 3'd0);
    chk("pre_rst_nivel", int'(nivel), 2);

    // Asynchronous reset in S2 while a numero press is mid-debounce.
    chaves = 8'h77;
    btn_numero = 1;
    repeat (3) tick();
    #2 rst = 1'b0;
    #1;
    chk("arst_entrada", int'(entrada), 0);
    chk("arst_operacao", int'(operacao), 0);
    chk("arst_nivel", int'(nivel), 0);
    chk("arst_strobes", int'({entrada_numero, executar, erro_sequencia, ocupado}), 0);
    @(negedge clk);
    rst = 1'b1;
    clear_counts();
    repeat (12) tick();
    btn_numero = 0;
    repeat (14) tick();
    chk("arst_num", n_num, 1);
    chk("arst_latency", first, 7);
    chk("arst_entrada_after", int'(entrada), 8'h77);
    chk("arst_nivel_after", int'(nivel), 1);

    chk("never_both_strobes", both, 0);
    chk("no_wide_strobe", wide, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
